// File: rtl/eb1_pkg.sv
// Shared types for the LSU fault pipe: the fault packet carried to the trap
// unit and the per-stage pipe entry with its fast-interrupt error tag.
package eb1_pkg;

  localparam int unsigned EB1_ADDR_W = 32;

  typedef enum logic [1:0] {
    FIR_NONE    = 2'b00,
    FIR_NONDCCM = 2'b01,
    FIR_DCCM    = 2'b10,
    FIR_ACCESS  = 2'b11
  } eb1_fir_code_e;

  typedef struct packed {
    logic                  exc_type;
    logic                  inst_type;
    logic [3:0]            mscause;
    logic [EB1_ADDR_W-1:0] addr;
  } eb1_lsu_fault_pkt_t;

  typedef struct packed {
    logic               fir;
    eb1_fir_code_e      fir_code;
    eb1_lsu_fault_pkt_t pkt;
  } eb1_lsu_fault_entry_t;

  // Non-DCCM error outranks DCCM error; a plain fault on a fast-int fetch
  // reports as an access error.
  function automatic eb1_fir_code_e eb1_fir_code(input logic nondccm, input logic dccm);
    if (nondccm)   return FIR_NONDCCM;
    else if (dccm) return FIR_DCCM;
    else           return FIR_ACCESS;
  endfunction

endpackage

// File: rtl/eb1_lsu_fault_stage.sv
// One pipe stage of the fault pipe: a valid bit plus payload, with a kill
// that drops the entry on its way in. Payload holds when nothing is loaded.
module eb1_lsu_fault_stage
  import eb1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_kill,
  input  eb1_lsu_fault_entry_t i_entry,
  output logic                 o_valid,
  output eb1_lsu_fault_entry_t o_entry
);

  logic                 r_valid;
  eb1_lsu_fault_entry_t r_entry;
  logic                 w_load;

  assign w_load = i_valid & ~i_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else begin
      r_valid <= w_load;
      if (w_load) r_entry <= i_entry;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/eb1_lsu_fault_pipe.sv
// LSU fault pipe: stages D-stage address-check faults through M and R, emits
// one error packet or fast-int error code at R, and keeps a sticky first-fault
// capture. Optional saturating fault counter under EB1_LSU_FAULT_CNT_EN.
module eb1_lsu_fault_pipe
  import eb1_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_valid_d,
  input  logic               lsu_store_d,
  input  logic               lsu_dma_d,
  input  logic               lsu_fast_int_d,
  input  logic [ADDR_W-1:0]  start_addr_d,
  input  logic               access_fault_d,
  input  logic               misaligned_fault_d,
  input  logic [3:0]         exc_mscause_d,
  input  logic               fir_dccm_access_error_d,
  input  logic               fir_nondccm_access_error_d,
  input  logic               flush_m,
  input  logic               flush_r,
  input  logic               clr_fault,
  output logic               err_valid_r,
  output eb1_lsu_fault_pkt_t err_pkt_r,
  output logic [1:0]         fir_error_r,
  output logic               fault_valid,
  output eb1_lsu_fault_pkt_t fault_pkt,
  output logic [CNT_W-1:0]   fault_cnt
);

  logic                 w_fault_d;
  logic                 w_fir_err_d;
  logic                 w_valid_d;
  eb1_lsu_fault_entry_t w_entry_d;
  logic                 w_valid_m;
  eb1_lsu_fault_entry_t w_entry_m;
  logic                 w_valid_r;
  eb1_lsu_fault_entry_t w_entry_r;

  logic                 r_fault_valid;
  eb1_lsu_fault_pkt_t   r_fault_pkt;

  assign w_fault_d   = access_fault_d | misaligned_fault_d;
  assign w_fir_err_d = lsu_fast_int_d & (fir_dccm_access_error_d | fir_nondccm_access_error_d);
  assign w_valid_d   = lsu_valid_d & ~lsu_dma_d & (w_fault_d | w_fir_err_d);

  always_comb begin
    w_entry_d               = '0;
    w_entry_d.fir           = lsu_fast_int_d;
    w_entry_d.fir_code      = eb1_fir_code(fir_nondccm_access_error_d, fir_dccm_access_error_d);
    w_entry_d.pkt.exc_type  = misaligned_fault_d;
    w_entry_d.pkt.inst_type = lsu_store_d;
    w_entry_d.pkt.mscause   = exc_mscause_d;
    w_entry_d.pkt.addr      = EB1_ADDR_W'(start_addr_d);
  end

  eb1_lsu_fault_stage u_stage_m (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_valid_d),
    .i_kill  (flush_m),
    .i_entry (w_entry_d),
    .o_valid (w_valid_m),
    .o_entry (w_entry_m)
  );

  eb1_lsu_fault_stage u_stage_r (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_valid_m),
    .i_kill  (flush_r),
    .i_entry (w_entry_m),
    .o_valid (w_valid_r),
    .o_entry (w_entry_r)
  );

  // Outputs decode straight from the R-stage flops, so they are registered.
  always_comb begin
    err_valid_r = w_valid_r & ~w_entry_r.fir;
    fir_error_r = FIR_NONE;
    if (w_valid_r & w_entry_r.fir) fir_error_r = w_entry_r.fir_code;
    err_pkt_r   = w_entry_r.pkt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_valid <= 1'b0;
      r_fault_pkt   <= '0;
    end else if (clr_fault) begin
      r_fault_valid <= err_valid_r;
      if (err_valid_r) r_fault_pkt <= err_pkt_r;
    end else if (err_valid_r & ~r_fault_valid) begin
      r_fault_valid <= 1'b1;
      r_fault_pkt   <= err_pkt_r;
    end
  end

  assign fault_valid = r_fault_valid;
  assign fault_pkt   = r_fault_pkt;

`ifdef EB1_LSU_FAULT_CNT_EN
  logic [CNT_W-1:0] r_fault_cnt;
  logic             w_cnt_evt;

  assign w_cnt_evt = err_valid_r | (fir_error_r != 2'b00);

  always_ff @(posedge clk) begin
    if (rst)
      r_fault_cnt <= '0;
    else if (clr_fault)
      r_fault_cnt <= CNT_W'(w_cnt_evt);
    else if (w_cnt_evt && (r_fault_cnt != '1))
      r_fault_cnt <= r_fault_cnt + CNT_W'(1);
  end

  assign fault_cnt = r_fault_cnt;
`else
  assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_eb1_lsu_fault_pipe.sv
// Bench for eb1_lsu_fault_pipe: a scoreboard of expected R-stage reports plus
// per-scenario tasks checking sticky capture and the optional counter.
module tb_eb1_lsu_fault_pipe;
  import eb1_pkg::*;

`ifdef EB1_LSU_FAULT_CNT_EN
  localparam int TB_CNT_W = 2;
  localparam bit CNT_EN   = 1'b1;
`else
  localparam int TB_CNT_W = 16;
  localparam bit CNT_EN   = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               lsu_valid_d = 1'b0;
  logic               lsu_store_d = 1'b0;
  logic               lsu_dma_d = 1'b0;
  logic               lsu_fast_int_d = 1'b0;
  logic [31:0]        start_addr_d = '0;
  logic               access_fault_d = 1'b0;
  logic               misaligned_fault_d = 1'b0;
  logic [3:0]         exc_mscause_d = '0;
  logic               fir_dccm_access_error_d = 1'b0;
  logic               fir_nondccm_access_error_d = 1'b0;
  logic               flush_m = 1'b0;
  logic               flush_r = 1'b0;
  logic               clr_fault = 1'b0;
  logic               err_valid_r;
  eb1_lsu_fault_pkt_t err_pkt_r;
  logic [1:0]         fir_error_r;
  logic               fault_valid;
  eb1_lsu_fault_pkt_t fault_pkt;
  logic [TB_CNT_W-1:0] fault_cnt;

  eb1_lsu_fault_pipe #(.ADDR_W(32), .CNT_W(TB_CNT_W)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .lsu_valid_d                (lsu_valid_d),
    .lsu_store_d                (lsu_store_d),
    .lsu_dma_d                  (lsu_dma_d),
    .lsu_fast_int_d             (lsu_fast_int_d),
    .start_addr_d               (start_addr_d),
    .access_fault_d             (access_fault_d),
    .misaligned_fault_d         (misaligned_fault_d),
    .exc_mscause_d              (exc_mscause_d),
    .fir_dccm_access_error_d    (fir_dccm_access_error_d),
    .fir_nondccm_access_error_d (fir_nondccm_access_error_d),
    .flush_m                    (flush_m),
    .flush_r                    (flush_r),
    .clr_fault                  (clr_fault),
    .err_valid_r                (err_valid_r),
    .err_pkt_r                  (err_pkt_r),
    .fir_error_r                (fir_error_r),
    .fault_valid                (fault_valid),
    .fault_pkt                  (fault_pkt),
    .fault_cnt                  (fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic               err;
    logic [1:0]         fir;
    eb1_lsu_fault_pkt_t pkt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every R-stage report is popped and compared, and an expected
  // report whose cycle has come without output is flagged.
  always @(negedge clk) begin
    exp_t e;
    if (err_valid_r === 1'b1 || fir_error_r !== 2'b00) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected cyc=%0d err_valid_r=%b fir_error_r=%b required no report",
                 cyc, err_valid_r, fir_error_r);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || err_valid_r !== e.err || fir_error_r !== e.fir ||
            (e.err && err_pkt_r !== e.pkt)) begin
          n_bad++;
          $display("FAIL sb_report cyc=%0d err=%b fir=%b pkt=%h required cyc=%0d err=%b fir=%b pkt=%h",
                   cyc, err_valid_r, fir_error_r, err_pkt_r, e.cyc, e.err, e.fir, e.pkt);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL sb_missing cyc=%0d err_valid_r=%b fir_error_r=%b required cyc=%0d err=%b fir=%b",
               cyc, err_valid_r, fir_error_r, e.cyc, e.err, e.fir);
    end
  end

  // Drive one D cycle; push the expected R report unless the scenario kills it.
  task automatic d_cycle(input logic v, st, dma, fi, input logic [31:0] a,
                         input logic acc, mis, input logic [3:0] msc,
                         input logic fdc, fnd, fm, fr, clr, kill);
    exp_t e;
    logic q;
    @(posedge clk); #1;
    lsu_valid_d = v; lsu_store_d = st; lsu_dma_d = dma; lsu_fast_int_d = fi;
    start_addr_d = a; access_fault_d = acc; misaligned_fault_d = mis;
    exc_mscause_d = msc; fir_dccm_access_error_d = fdc;
    fir_nondccm_access_error_d = fnd; flush_m = fm; flush_r = fr; clr_fault = clr;
    q = v & ~dma & (acc | mis | (fi & (fdc | fnd)));
    if (q && !kill) begin
      e.cyc = cyc + 2;
      e.err = ~fi;
      e.fir = !fi ? 2'b00 : fnd ? 2'b01 : fdc ? 2'b10 : 2'b11;
      e.pkt = '{exc_type: mis, inst_type: st, mscause: msc, addr: a};
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) d_cycle(0,0,0,0,32'h0,0,0,4'h0,0,0,0,0,0,0);
  endtask

  task automatic fault(input logic [31:0] a, input logic st, acc, mis, input logic [3:0] msc);
    d_cycle(1,st,0,0,a,acc,mis,msc,0,0,0,0,0,0);
  endtask

  task automatic do_reset();
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (err_valid_r !== 1'b0 || fir_error_r !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_outputs got err=%b fir=%b required 0/00", err_valid_r, fir_error_r);
    end
    n_cmp++;
    if (fault_valid !== 1'b0 || fault_pkt !== '0 || fault_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_sticky got valid=%b pkt=%h cnt=%0d required 0/0/0",
               fault_valid, fault_pkt, fault_cnt);
    end
    // Fault in flight when reset hits must vanish with no report or capture.
    d_cycle(1,0,0,0,32'hDEAD_0000,1,0,4'h3,0,0,0,0,0,1);
    do_reset();
    idle(3);
    n_cmp++;
    if (fault_valid !== 1'b0 || fault_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_midop got valid=%b cnt=%0d required 0/0", fault_valid, fault_cnt);
    end
  endtask

  task automatic test_load_fault();
    eb1_lsu_fault_pkt_t p;
    p = '{exc_type: 1'b0, inst_type: 1'b0, mscause: 4'h2, addr: 32'hF004_0001};
    fault(32'hF004_0001, 0, 1, 0, 4'h2);
    idle(2);
    n_cmp++;
    if (err_valid_r !== 1'b1 || fault_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL load_cycle2 got err=%b fault_valid=%b required 1/0", err_valid_r, fault_valid);
    end
    idle(1);
    n_cmp++;
    if (fault_valid !== 1'b1 || fault_pkt !== p) begin
      n_bad++;
      $display("FAIL load_capture got valid=%b pkt=%h required 1/%h", fault_valid, fault_pkt, p);
    end
  endtask

  task automatic test_store_misaligned();
    fault(32'h1234_5678, 1, 1, 1, 4'h1);
    idle(3);
    n_cmp++;
    if (fault_pkt.addr !== 32'hF004_0001 || fault_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL sticky_hold got valid=%b addr=%h required 1/f0040001", fault_valid, fault_pkt.addr);
    end
  endtask

  task automatic test_flush();
    d_cycle(1,0,0,0,32'hA000_0001,1,0,4'h5,0,0,1,0,0,1);
    idle(3);
    d_cycle(1,0,0,0,32'hA000_0002,1,0,4'h5,0,0,0,0,0,1);
    d_cycle(0,0,0,0,32'h0,0,0,4'h0,0,0,0,1,0,0);
    idle(3);
    fault(32'hA000_0003, 0, 1, 0, 4'h6);
    d_cycle(1,1,0,0,32'hA000_0004,0,1,4'h7,0,0,0,0,0,1);
    d_cycle(0,0,0,0,32'h0,0,0,4'h0,0,0,0,1,0,0);
    idle(3);
    // Both flushes together: older entry dies M->R, younger dies D->M.
    d_cycle(1,0,0,0,32'hA000_0005,1,0,4'h1,0,0,0,0,0,1);
    d_cycle(1,0,0,0,32'hA000_0006,1,0,4'h1,0,0,1,1,0,1);
    idle(3);
  endtask

  task automatic test_fir();
    d_cycle(0,0,0,0,32'h0,0,0,4'h0,0,0,0,0,1,0);
    idle(1);
    n_cmp++;
    if (fault_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_fault got valid=%b required 0", fault_valid);
    end
    d_cycle(1,0,0,1,32'hB000_0000,0,0,4'h0,1,1,0,0,0,0);
    d_cycle(1,0,0,1,32'hB000_0004,0,0,4'h0,1,0,0,0,0,0);
    d_cycle(1,0,0,1,32'hB000_0008,1,0,4'h2,0,0,0,0,0,0);
    idle(3);
    n_cmp++;
    if (fault_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fir_not_captured got valid=%b required 0", fault_valid);
    end
  endtask

  task automatic test_sticky();
    fault(32'h0000_0100, 0, 1, 0, 4'h4);
    fault(32'h0000_0200, 1, 1, 0, 4'h4);
    idle(3);
    n_cmp++;
    if (fault_valid !== 1'b1 || fault_pkt.addr !== 32'h100) begin
      n_bad++;
      $display("FAIL sticky_first got valid=%b addr=%h required 1/100", fault_valid, fault_pkt.addr);
    end
    fault(32'h0000_0200, 1, 1, 0, 4'h4);
    idle(1);
    d_cycle(0,0,0,0,32'h0,0,0,4'h0,0,0,0,0,1,0);
    idle(1);
    n_cmp++;
    if (fault_valid !== 1'b1 || fault_pkt.addr !== 32'h200) begin
      n_bad++;
      $display("FAIL sticky_clr_coincident got valid=%b addr=%h required 1/200",
               fault_valid, fault_pkt.addr);
    end
  endtask

  task automatic test_counter();
    do_reset();
    d_cycle(1,0,1,0,32'hC000_0000,1,0,4'h2,0,0,0,0,0,0);
    idle(3);
    n_cmp++;
    if (fault_cnt !== '0) begin
      n_bad++;
      $display("FAIL cnt_dma got %0d required 0", fault_cnt);
    end
    for (int i = 0; i < 5; i++) fault(32'hC000_0010 + 32'(i), 0, 1, 0, 4'h2);
    idle(3);
    n_cmp++;
    if (fault_cnt !== TB_CNT_W'(CNT_EN ? 3 : 0)) begin
      n_bad++;
      $display("FAIL cnt_saturate got %0d required %0d", fault_cnt, CNT_EN ? 3 : 0);
    end
    do_reset();
    n_cmp++;
    if (fault_cnt !== '0) begin
      n_bad++;
      $display("FAIL cnt_reset got %0d required 0", fault_cnt);
    end
    fault(32'hC000_0100, 0, 1, 0, 4'h2);
    fault(32'hC000_0104, 0, 1, 0, 4'h2);
    d_cycle(0,0,0,0,32'h0,0,0,4'h0,0,0,0,0,0,0);
    d_cycle(0,0,0,0,32'h0,0,0,4'h0,0,0,0,0,1,0);
    idle(1);
    n_cmp++;
    if (fault_cnt !== TB_CNT_W'(CNT_EN ? 1 : 0)) begin
      n_bad++;
      $display("FAIL cnt_clr_coincident got %0d required %0d", fault_cnt, CNT_EN ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_load_fault();
    test_store_misaligned();
    test_flush();
    test_fir();
    test_sticky();
    test_counter();
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eb1_lsu_fault_pipe.md
Name: eb1_lsu_fault_pipe

Overview:
Downstream consumer of the LSU D-stage address check. Stages its fault results (access/misaligned fault, mscause, fast-interrupt errors) with the address through M to R. At R it emits one error packet to the trap unit, honouring per-stage flushes. Also holds a sticky first-fault capture register for debug/CSR readout.

Parameters:
ADDR_W, 32, address width carried with the fault
CNT_W, 16, width of the optional fault counter

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous, active-high
lsu_valid_d  in  1  LSU packet valid in D
lsu_store_d  in  1  packet is store (else load)
lsu_dma_d  in  1  DMA access; never faults here
lsu_fast_int_d  in  1  fast-interrupt vector fetch
start_addr_d  in  ADDR_W  access start address
access_fault_d  in  1  access fault from address check
misaligned_fault_d  in  1  misaligned fault from address check
exc_mscause_d  in  4  mscause from address check
fir_dccm_access_error_d  in  1  fast-int DCCM error
fir_nondccm_access_error_d  in  1  fast-int non-DCCM error
flush_m  in  1  kill entry moving D->M
flush_r  in  1  kill entry moving M->R
clr_fault  in  1  clear sticky capture
err_valid_r  out  1  error packet valid (load/store exception)
err_pkt_r  out  eb1_lsu_fault_pkt_t  {exc_type, inst_type, mscause[3:0], addr}
fir_error_r  out  2  fast-int error code
fault_valid  out  1  sticky capture holds a fault
fault_pkt  out  eb1_lsu_fault_pkt_t  first captured fault
fault_cnt  out  CNT_W  fault count (optional feature, else 0)

Behaviour:
- Reset (rst high at a clk edge): all stage valids, err_valid_r, fir_error_r, fault_valid, fault_pkt, fault_cnt = 0. Reset mid-operation discards in-flight entries; no output pulse follows.
- D qualification: entry valid only when lsu_valid_d & ~lsu_dma_d & (fault or fir error). Non-faulting packets carry nothing.
- exc_type = 1 if misaligned_fault_d else 0 (misaligned wins). mscause passes through unchanged. inst_type = lsu_store_d.
- Fast-int entries set a fir flag. Encoding: fir_nondccm -> 2'b01, else fir_dccm -> 2'b10, else any access/misaligned fault -> 2'b11.
- Pipeline: D->M one cycle, M->R one cycle. err_valid_r/fir_error_r are registered outputs, asserted exactly two cycles after the faulting D cycle, for one cycle only. The pipe does not stall.
- flush_m: M valid loads 0 that cycle. flush_r: R valid loads 0. Both together: both killed.
- err_valid_r = R valid & ~fir. fir_error_r = R valid & fir ? code : 2'b00. They are never both nonzero.
- err_pkt_r holds the last loaded value when invalid. The bench checks it only under err_valid_r.
- Sticky capture: on err_valid_r & ~fault_valid, load fault_pkt and set fault_valid. Later faults are ignored.
- clr_fault clears fault_valid. clr_fault coincident with err_valid_r: the new fault is captured (fault_valid stays 1).
- fir errors are not captured.

Optional Feature:
- Macro: EB1_LSU_FAULT_CNT_EN.
- Defined: fault_cnt increments on each err_valid_r or nonzero fir_error_r. It saturates at all-ones and is cleared by rst or clr_fault. On clr_fault with a coincident fault, fault_cnt = 1.
- Undefined: no counter flops; fault_cnt tied 0.

Decomposition:
- eb1_pkg: eb1_lsu_fault_pkt_t (exc_type, inst_type, mscause[3:0], addr[31:0]) and fir code constants FIR_NONDCCM=2'b01, FIR_DCCM=2'b10, FIR_ACCESS=2'b11.
- Sub-module eb1_lsu_fault_stage: one valid+payload register with kill input. Instantiated for M and R.

Test Plan:
- Load, addr 0xF004_0001, access_fault=1, mscause=2 at cycle 0 -> cycle 2: err_valid_r=1, exc_type=0, inst_type=0, mscause=2, addr=0xF0040001; fault_valid=1 from cycle 3.
- Store, misaligned=1 & access=1, mscause=1 -> err_pkt_r exc_type=1, inst_type=1, mscause=1.
- Fault at cycle 0 with flush_m at cycle 0 -> no output. Fault at cycle 0 with flush_r at cycle 1 -> no output. Faults on back-to-back cycles with flush_r at cycle 2 -> only the first reported.
- fast_int with fir_nondccm=1 and fir_dccm=1 -> fir_error_r=2'b01, err_valid_r=0, fault_valid unchanged.
- Two faults (addr 0x100, then 0x200) -> fault_pkt.addr=0x100. clr_fault coincident with the 0x200 report -> fault_pkt.addr=0x200, fault_valid=1.
- With EB1_LSU_FAULT_CNT_EN and CNT_W=2: 5 faults -> fault_cnt=3 (saturated); rst pulse -> 0. lsu_dma_d=1 fault -> no output, counter unchanged.
